// File: rtl/gmii_frame_generator_if.sv
// GMII transmit bus shared by the frame generator (master) and whatever samples it (slave).
interface gmii_frame_generator_if;
    logic [7:0] gmii_d;
    logic       gmii_en;
    logic       gmii_er;

    modport master (output gmii_d, output gmii_en, output gmii_er);
    modport slave  (input  gmii_d, input  gmii_en, input  gmii_er);
endinterface

// File: rtl/gmii_frame_generator.sv
// GMII test-frame generator: preamble, SFD, header + counting payload, optional FCS, gap.
// Define GMII_FRAME_GENERATOR_FCS_EN to append an Ethernet CRC-32 after the data bytes.
module gmii_frame_generator #(
    parameter int C_MAX_FRAME_LEN = 2044,
    parameter int C_MIN_IFG       = 12
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          stop,
    input  logic [15:0]                   frame_len,
    input  logic [7:0]                    ifg_len,
    input  logic [31:0]                   frame_count,
    input  logic [47:0]                   dst_mac,
    input  logic [47:0]                   src_mac,
    gmii_frame_generator_if.master        gmii,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   pkts_sent
);

    localparam logic [15:0] MIN_LEN = 16'd14;
    localparam logic [15:0] MAX_LEN = 16'(C_MAX_FRAME_LEN);
    localparam logic [7:0]  MIN_IFG = 8'(C_MIN_IFG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
`ifdef GMII_FRAME_GENERATOR_FCS_EN
        S_FCS,
`endif
        S_IFG
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  gap_q, gap_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [7:0]  seq_q, seq_d;
    logic [31:0] target_q, target_d;
    logic [31:0] burst_q, burst_d;
    logic [31:0] pkts_q, pkts_d;
    logic        ready_q;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        launch;
    logic        frame_end;
    logic        reached;
`ifdef GMII_FRAME_GENERATOR_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs;
`endif

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    mac_byte = mac[47:40];
            3'd1:    mac_byte = mac[39:32];
            3'd2:    mac_byte = mac[31:24];
            3'd3:    mac_byte = mac[23:16];
            3'd4:    mac_byte = mac[15:8];
            3'd5:    mac_byte = mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    endfunction

`ifdef GMII_FRAME_GENERATOR_FCS_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] r;
        r = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction
`endif

    assign reached = (target_q != 32'd0) && (burst_q >= target_q);

    // ready_q holds off the first launch until the second edge after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            len_q    <= MIN_LEN;
            gap_q    <= MIN_IFG;
            dst_q    <= '0;
            src_q    <= '0;
            seq_q    <= '0;
            target_q <= '0;
            burst_q  <= '0;
            pkts_q   <= '0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef GMII_FRAME_GENERATOR_FCS_EN
            crc_q    <= '1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            seq_q    <= seq_d;
            target_q <= target_d;
            burst_q  <= burst_d;
            pkts_q   <= pkts_d;
            ready_q  <= 1'b1;
            data_q   <= data_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef GMII_FRAME_GENERATOR_FCS_EN
            crc_q    <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        gap_d     = gap_q;
        dst_d     = dst_q;
        src_d     = src_q;
        seq_d     = seq_q;
        target_d  = target_q;
        burst_d   = burst_q;
        pkts_d    = pkts_q;
        done_d    = 1'b0;
        launch    = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready_q && start && !stop) begin
                    launch   = 1'b1;
                    burst_d  = '0;
                    target_d = frame_count;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q == 16'd6) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SFD: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                if (cnt_q == len_q - 16'd1) begin
                    cnt_d = '0;
`ifdef GMII_FRAME_GENERATOR_FCS_EN
                    state_d = S_FCS;
`else
                    state_d   = S_IFG;
                    frame_end = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef GMII_FRAME_GENERATOR_FCS_EN
            S_FCS: begin
                if (cnt_q == 16'd3) begin
                    state_d   = S_IFG;
                    cnt_d     = '0;
                    frame_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            S_IFG: begin
                if (cnt_q == {8'd0, gap_q} - 16'd1) begin
                    if (stop || !start || reached) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = reached;
                    end else begin
                        launch = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame parameters are captured only here, so mid-frame input changes wait a frame
        if (launch) begin
            state_d = S_PREAMBLE;
            cnt_d   = '0;
            len_d   = (frame_len < MIN_LEN) ? MIN_LEN : ((frame_len > MAX_LEN) ? MAX_LEN : frame_len);
            gap_d   = (ifg_len < MIN_IFG) ? MIN_IFG : ifg_len;
            dst_d   = dst_mac;
            src_d   = src_mac;
            seq_d   = pkts_q[7:0];
        end

        if (frame_end) begin
            pkts_d  = pkts_q + 32'd1;
            burst_d = burst_q + 32'd1;
        end
    end

    // Outputs are decoded from the next state so the registered bus lines up with state_q
    always_comb begin
        en_d   = 1'b0;
        data_d = 8'h00;
        busy_d = (state_d != S_IDLE);
`ifdef GMII_FRAME_GENERATOR_FCS_EN
        crc_d  = crc_q;
        fcs    = ~crc_q;
`endif

        case (state_d)
            S_PREAMBLE: begin
                en_d   = 1'b1;
                data_d = 8'h55;
            end
            S_SFD: begin
                en_d   = 1'b1;
                data_d = 8'hD5;
            end
            S_DATA: begin
                en_d = 1'b1;
                if (cnt_d < 16'd6) begin
                    data_d = mac_byte(dst_q, cnt_d[2:0]);
                end else if (cnt_d < 16'd12) begin
                    data_d = mac_byte(src_q, cnt_d[2:0] - 3'd6);
                end else if (cnt_d == 16'd12) begin
                    data_d = 8'h88;
                end else if (cnt_d == 16'd13) begin
                    data_d = 8'hB5;
                end else begin
                    data_d = seq_q + cnt_d[7:0] - 8'd14;
                end
            end
`ifdef GMII_FRAME_GENERATOR_FCS_EN
            S_FCS: begin
                en_d = 1'b1;
                case (cnt_d[1:0])
                    2'd0:    data_d = fcs[7:0];
                    2'd1:    data_d = fcs[15:8];
                    2'd2:    data_d = fcs[23:16];
                    default: data_d = fcs[31:24];
                endcase
            end
`endif
            default: ;
        endcase

`ifdef GMII_FRAME_GENERATOR_FCS_EN
        if (state_d == S_PREAMBLE) begin
            crc_d = '1;
        end else if (state_d == S_DATA) begin
            crc_d = crc_byte(crc_q, data_d);
        end
`endif
    end

    assign gmii.gmii_d  = data_q;
    assign gmii.gmii_en = en_q;
    assign gmii.gmii_er = 1'b0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pkts_sent    = pkts_q;

endmodule

// File: tb/tb_gmii_frame_generator.sv
// Randomized self-checking bench for gmii_frame_generator against a byte-stream reference model.
module tb_gmii_frame_generator;

    localparam int MAX_LEN = 2044;
    localparam int MIN_IFG = 12;
`ifdef GMII_FRAME_GENERATOR_FCS_EN
    localparam int FCS_BYTES = 4;
`else
    localparam int FCS_BYTES = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] frame_len = 16'd64;
    logic [7:0]  ifg_len = 8'd12;
    logic [31:0] frame_count = 32'd1;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic        busy;
    logic        done;
    logic [31:0] pkts_sent;

    gmii_frame_generator_if gmii ();

    gmii_frame_generator #(.C_MAX_FRAME_LEN(MAX_LEN), .C_MIN_IFG(MIN_IFG)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .frame_len   (frame_len),
        .ifg_len     (ifg_len),
        .frame_count (frame_count),
        .dst_mac     (dst_mac),
        .src_mac     (src_mac),
        .gmii        (gmii),
        .busy        (busy),
        .done        (done),
        .pkts_sent   (pkts_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int model_pkts = 0;

    // Captured bus activity
    logic [7:0] cap_bytes[$];
    int         cap_lens[$];
    int         cap_gaps[$];
    int         done_cnt;
    int         tail_idle;
    int         idle_viol;
    bit         timed_out;

    // Requested per-frame parameters and the model's expected stream
    int          prm_len[$];
    logic [47:0] prm_dst[$];
    logic [47:0] prm_src[$];
    logic [7:0]  exp_all[$];
    int          exp_lens[$];

    // Values applied by the mid-frame hook
    int          nxt_len;
    int          nxt_ifg;
    logic [47:0] nxt_dst;
    logic [47:0] nxt_src;

    function automatic int eff_len(input int fl);
        return (fl < 14) ? 14 : ((fl > MAX_LEN) ? MAX_LEN : fl);
    endfunction

    function automatic int eff_gap(input int g);
        return (g < MIN_IFG) ? MIN_IFG : g;
    endfunction

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic void build_expected(input int seq0);
        exp_all.delete();
        exp_lens.delete();
        for (int f = 0; f < prm_len.size(); f++) begin
            int          n;
            logic [31:0] crc;
            logic [7:0]  b;
            logic [47:0] d;
            logic [47:0] s;
            n   = eff_len(prm_len[f]);
            crc = 32'hFFFF_FFFF;
            d   = prm_dst[f];
            s   = prm_src[f];
            for (int i = 0; i < 7; i++) exp_all.push_back(8'h55);
            exp_all.push_back(8'hD5);
            for (int k = 0; k < n; k++) begin
                if (k < 6)        b = 8'(d >> (8 * (5 - k)));
                else if (k < 12)  b = 8'(s >> (8 * (11 - k)));
                else if (k == 12) b = 8'h88;
                else if (k == 13) b = 8'hB5;
                else              b = 8'((seq0 + f + k - 14) % 256);
                crc = crc_model(crc, b);
                exp_all.push_back(b);
            end
            for (int j = 0; j < FCS_BYTES; j++) exp_all.push_back(8'(~crc >> (8 * j)));
            exp_lens.push_back(8 + n + FCS_BYTES);
        end
    endfunction

    task automatic set_frame(input int len, input int ifg, input int cnt, input logic [47:0] d, input logic [47:0] s);
        frame_len   = 16'(len);
        ifg_len     = 8'(ifg);
        frame_count = 32'(cnt);
        dst_mac     = d;
        src_mac     = s;
    endtask

    // hook_kind: 0 none, 1 raise stop, 2 load nxt_* inputs
    task automatic capture(input int max_cycles, input int hook_frame, input int hook_byte, input int hook_kind);
        int idle_run;
        int cur;
        int nfr;
        bit in_fr;
        bit fin;
        cap_bytes.delete();
        cap_lens.delete();
        cap_gaps.delete();
        done_cnt  = 0;
        tail_idle = -1;
        idle_viol = 0;
        timed_out = 1'b0;
        idle_run  = 0;
        cur       = 0;
        nfr       = 0;
        in_fr     = 1'b0;
        fin       = 1'b0;
        for (int c = 0; c < max_cycles && !fin; c++) begin
            @(negedge clk);
            if (gmii.gmii_er !== 1'b0) idle_viol++;
            if (gmii.gmii_en === 1'b1) begin
                if (!in_fr) begin
                    in_fr = 1'b1;
                    cur   = 0;
                    if (nfr > 0) cap_gaps.push_back(idle_run);
                end
                cap_bytes.push_back(gmii.gmii_d);
                cur++;
                if (nfr == hook_frame && cur == 8 + hook_byte + 1) begin
                    if (hook_kind == 1) stop = 1'b1;
                    else if (hook_kind == 2) set_frame(nxt_len, nxt_ifg, int'(frame_count), nxt_dst, nxt_src);
                end
            end else begin
                if (gmii.gmii_d !== 8'h00) idle_viol++;
                if (in_fr) begin
                    in_fr = 1'b0;
                    cap_lens.push_back(cur);
                    nfr++;
                    idle_run = 0;
                end
                if (done === 1'b1) done_cnt++;
                if (nfr > 0 && busy === 1'b0) begin
                    tail_idle = idle_run;
                    fin = 1'b1;
                end
                idle_run++;
            end
        end
        if (!fin) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (gmii.gmii_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_en: got %b want 0", gmii.gmii_en); end
        total++; if (gmii.gmii_d !== 8'h00) begin bad++; $display("[TB] FAIL rst_d: got %h want 00", gmii.gmii_d); end
        total++; if (gmii.gmii_er !== 1'b0) begin bad++; $display("[TB] FAIL rst_er: got %b want 0", gmii.gmii_er); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b want 0", done); end
        total++; if (pkts_sent !== 32'd0) begin bad++; $display("[TB] FAIL rst_pkts: got %0d want 0", pkts_sent); end
        resetn = 1'b1;
        @(negedge clk);
        total++; if (gmii.gmii_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_first_edge_en: got %b want 0", gmii.gmii_en); end
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_stay_idle: busy got %b want 0", busy); end
        model_pkts = 0;
    endtask

    task automatic test_sequence();
        int len, ifg, seq0, mis, base, gap_bad;
        logic [31:0] r;
        logic [31:0] rev;
        len  = $urandom_range(15, 80);
        ifg  = $urandom_range(0, 20);
        seq0 = model_pkts;
        set_frame(len, ifg, 3, {$urandom, $urandom}, {$urandom, $urandom});
        prm_len = '{len, len, len};
        prm_dst = '{dst_mac, dst_mac, dst_mac};
        prm_src = '{src_mac, src_mac, src_mac};
        build_expected(seq0);
        start = 1'b1;
        capture(6000, -1, 0, 0);
        start = 1'b0;
        model_pkts += 3;
        total++; if (timed_out) begin bad++; $display("[TB] FAIL seq_timeout: burst did not finish"); end
        total++; if (cap_lens.size() != 3) begin bad++; $display("[TB] FAIL seq_frames: got %0d want 3", cap_lens.size()); end
        mis = -1;
        for (int i = 0; i < exp_all.size(); i++)
            if (mis < 0 && (i >= cap_bytes.size() || cap_bytes[i] !== exp_all[i])) mis = i;
        if (mis < 0 && cap_bytes.size() != exp_all.size()) mis = exp_all.size();
        total++; if (mis >= 0) begin bad++; $display("[TB] FAIL seq_bytes: first diff at %0d, got %0d bytes want %0d", mis, cap_bytes.size(), exp_all.size()); end
        gap_bad = 0;
        foreach (cap_gaps[i]) if (cap_gaps[i] != eff_gap(ifg)) gap_bad++;
        total++; if (gap_bad != 0 || cap_gaps.size() != 2) begin bad++; $display("[TB] FAIL seq_gaps: %0d wrong of %0d, want gap %0d", gap_bad, cap_gaps.size(), eff_gap(ifg)); end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL seq_done: got %0d pulses want 1", done_cnt); end
        total++; if (tail_idle != eff_gap(ifg)) begin bad++; $display("[TB] FAIL seq_tail_gap: got %0d want %0d", tail_idle, eff_gap(ifg)); end
        total++; if (pkts_sent !== 32'(model_pkts)) begin bad++; $display("[TB] FAIL seq_pkts: got %0d want %0d", pkts_sent, model_pkts); end
        total++; if (idle_viol != 0) begin bad++; $display("[TB] FAIL seq_idle_bus: got %0d bad idle cycles want 0", idle_viol); end
        base = 2 * (8 + eff_len(len) + FCS_BYTES) + 8 + 14;
        total++;
        if (base >= cap_bytes.size() || cap_bytes[base] !== 8'(seq0 + 2)) begin
            bad++; $display("[TB] FAIL seq_frame3_byte14: got %h want %h", (base < cap_bytes.size()) ? cap_bytes[base] : 8'hXX, 8'(seq0 + 2));
        end
`ifdef GMII_FRAME_GENERATOR_FCS_EN
        for (int f = 0; f < 3 && (f + 1) * (8 + eff_len(len) + 4) <= cap_bytes.size(); f++) begin
            r = 32'hFFFF_FFFF;
            for (int i = 8; i < 8 + eff_len(len) + 4; i++) r = crc_model(r, cap_bytes[f * (8 + eff_len(len) + 4) + i]);
            rev = {<<{r}};
            total++; if (rev !== 32'hC704_DD7B) begin bad++; $display("[TB] FAIL seq_residue: frame %0d got %h want c704dd7b", f, rev); end
        end
`endif
    endtask

    task automatic test_single_frame();
        int mis, dst_bad;
        logic [7:0] want_dst [6];
        want_dst = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        set_frame(64, 0, 1, 48'h0A0B_0C0D_0E0F, {$urandom, $urandom});
        prm_len = '{64};
        prm_dst = '{dst_mac};
        prm_src = '{src_mac};
        build_expected(model_pkts);
        start = 1'b1;
        capture(2000, -1, 0, 0);
        start = 1'b0;
        model_pkts += 1;
        total++; if (timed_out || cap_lens.size() != 1) begin bad++; $display("[TB] FAIL single_frames: got %0d want 1 (timeout=%0d)", cap_lens.size(), timed_out); end
        total++; if (cap_lens.size() < 1 || cap_lens[0] != 72 + FCS_BYTES) begin bad++; $display("[TB] FAIL single_en_cycles: got %0d want %0d", (cap_lens.size() > 0) ? cap_lens[0] : -1, 72 + FCS_BYTES); end
        dst_bad = 0;
        for (int i = 0; i < 6; i++) if (8 + i >= cap_bytes.size() || cap_bytes[8 + i] !== want_dst[i]) dst_bad++;
        total++; if (dst_bad != 0) begin bad++; $display("[TB] FAIL single_dst: got %0d wrong bytes want 0", dst_bad); end
        mis = -1;
        for (int i = 0; i < exp_all.size(); i++)
            if (mis < 0 && (i >= cap_bytes.size() || cap_bytes[i] !== exp_all[i])) mis = i;
        if (mis < 0 && cap_bytes.size() != exp_all.size()) mis = exp_all.size();
        total++; if (mis >= 0) begin bad++; $display("[TB] FAIL single_bytes: first diff at %0d, got %0d bytes want %0d", mis, cap_bytes.size(), exp_all.size()); end
        total++; if (done_cnt != 1 || tail_idle != 12) begin bad++; $display("[TB] FAIL single_done: got %0d pulses after %0d idle, want 1 after 12", done_cnt, tail_idle); end
        total++; if (pkts_sent !== 32'(model_pkts)) begin bad++; $display("[TB] FAIL single_pkts: got %0d want %0d", pkts_sent, model_pkts); end
    endtask

    task automatic test_min_clamp();
        int mis, len_bad;
        set_frame(5, 3, 3, {$urandom, $urandom}, {$urandom, $urandom});
        prm_len = '{5, 5, 5};
        prm_dst = '{dst_mac, dst_mac, dst_mac};
        prm_src = '{src_mac, src_mac, src_mac};
        build_expected(model_pkts);
        start = 1'b1;
        capture(2000, -1, 0, 0);
        start = 1'b0;
        model_pkts += 3;
        len_bad = 0;
        foreach (cap_lens[i]) if (cap_lens[i] != 8 + 14 + FCS_BYTES) len_bad++;
        total++; if (cap_lens.size() != 3 || len_bad != 0) begin bad++; $display("[TB] FAIL min_lens: %0d frames, %0d wrong length, want 3 of %0d", cap_lens.size(), len_bad, 22 + FCS_BYTES); end
        total++; if (cap_gaps.size() != 2 || cap_gaps[0] != 12 || cap_gaps[1] != 12) begin bad++; $display("[TB] FAIL min_gaps: got %0d gaps, first %0d, want 2 of 12", cap_gaps.size(), (cap_gaps.size() > 0) ? cap_gaps[0] : -1); end
        mis = -1;
        for (int i = 0; i < exp_all.size(); i++)
            if (mis < 0 && (i >= cap_bytes.size() || cap_bytes[i] !== exp_all[i])) mis = i;
        if (mis < 0 && cap_bytes.size() != exp_all.size()) mis = exp_all.size();
        total++; if (mis >= 0) begin bad++; $display("[TB] FAIL min_bytes: first diff at %0d, got %0d bytes want %0d", mis, cap_bytes.size(), exp_all.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL min_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_max_clamp();
        int len, ifg, mis;
        len = $urandom_range(MAX_LEN + 1, 65535);
        ifg = $urandom_range(13, 40);
        set_frame(len, ifg, 1, {$urandom, $urandom}, {$urandom, $urandom});
        prm_len = '{len};
        prm_dst = '{dst_mac};
        prm_src = '{src_mac};
        build_expected(model_pkts);
        start = 1'b1;
        capture(4000, -1, 0, 0);
        start = 1'b0;
        model_pkts += 1;
        total++; if (cap_lens.size() != 1 || cap_lens[0] != 8 + MAX_LEN + FCS_BYTES) begin bad++; $display("[TB] FAIL max_len: got %0d want %0d", (cap_lens.size() > 0) ? cap_lens[0] : -1, 8 + MAX_LEN + FCS_BYTES); end
        mis = -1;
        for (int i = 0; i < exp_all.size(); i++)
            if (mis < 0 && (i >= cap_bytes.size() || cap_bytes[i] !== exp_all[i])) mis = i;
        if (mis < 0 && cap_bytes.size() != exp_all.size()) mis = exp_all.size();
        total++; if (mis >= 0) begin bad++; $display("[TB] FAIL max_bytes: first diff at %0d, got %0d bytes want %0d", mis, cap_bytes.size(), exp_all.size()); end
        total++; if (tail_idle != ifg) begin bad++; $display("[TB] FAIL max_gap: got %0d want %0d", tail_idle, ifg); end
    endtask

    task automatic test_stop_continuous();
        int len, mis;
        len = $urandom_range(30, 60);
        set_frame(len, 0, 0, {$urandom, $urandom}, {$urandom, $urandom});
        prm_len = '{len, len};
        prm_dst = '{dst_mac, dst_mac};
        prm_src = '{src_mac, src_mac};
        build_expected(model_pkts);
        start = 1'b1;
        capture(2000, 1, 20, 1);
        start = 1'b0;
        stop  = 1'b0;
        model_pkts += 2;
        total++; if (timed_out || cap_lens.size() != 2) begin bad++; $display("[TB] FAIL stop_frames: got %0d want 2 (timeout=%0d)", cap_lens.size(), timed_out); end
        mis = -1;
        for (int i = 0; i < exp_all.size(); i++)
            if (mis < 0 && (i >= cap_bytes.size() || cap_bytes[i] !== exp_all[i])) mis = i;
        if (mis < 0 && cap_bytes.size() != exp_all.size()) mis = exp_all.size();
        total++; if (mis >= 0) begin bad++; $display("[TB] FAIL stop_bytes: first diff at %0d, got %0d bytes want %0d", mis, cap_bytes.size(), exp_all.size()); end
        total++; if (tail_idle != 12) begin bad++; $display("[TB] FAIL stop_tail_gap: got %0d want 12", tail_idle); end
        total++; if (done_cnt != 0) begin bad++; $display("[TB] FAIL stop_done: got %0d pulses want 0", done_cnt); end
        total++; if (pkts_sent !== 32'(model_pkts)) begin bad++; $display("[TB] FAIL stop_pkts: got %0d want %0d", pkts_sent, model_pkts); end
    endtask

    task automatic test_midframe_change();
        int len_a, ifg_a, mis;
        len_a   = $urandom_range(20, 50);
        ifg_a   = $urandom_range(12, 30);
        nxt_len = $urandom_range(14, 50);
        nxt_ifg = $urandom_range(31, 60);
        nxt_dst = {$urandom, $urandom};
        nxt_src = {$urandom, $urandom};
        set_frame(len_a, ifg_a, 2, {$urandom, $urandom}, {$urandom, $urandom});
        prm_len = '{len_a, nxt_len};
        prm_dst = '{dst_mac, nxt_dst};
        prm_src = '{src_mac, nxt_src};
        build_expected(model_pkts);
        start = 1'b1;
        capture(2000, 0, 16, 2);
        start = 1'b0;
        model_pkts += 2;
        mis = -1;
        for (int i = 0; i < exp_all.size(); i++)
            if (mis < 0 && (i >= cap_bytes.size() || cap_bytes[i] !== exp_all[i])) mis = i;
        if (mis < 0 && cap_bytes.size() != exp_all.size()) mis = exp_all.size();
        total++; if (mis >= 0) begin bad++; $display("[TB] FAIL change_bytes: first diff at %0d, got %0d bytes want %0d", mis, cap_bytes.size(), exp_all.size()); end
        total++; if (cap_gaps.size() != 1 || cap_gaps[0] != ifg_a) begin bad++; $display("[TB] FAIL change_gap1: got %0d want %0d", (cap_gaps.size() > 0) ? cap_gaps[0] : -1, ifg_a); end
        total++; if (tail_idle != nxt_ifg) begin bad++; $display("[TB] FAIL change_gap2: got %0d want %0d", tail_idle, nxt_ifg); end
    endtask

    task automatic test_reset_midframe();
        int seen, got;
        bit hit;
        bit idle;
        logic [7:0] pre[$];
        set_frame($urandom_range(40, 80), 0, 0, {$urandom, $urandom}, {$urandom, $urandom});
        start = 1'b1;
        seen  = 0;
        hit   = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (gmii.gmii_en === 1'b1) begin
                seen++;
                if (seen == 8 + 30 + 1) hit = 1'b1;
            end
        end
        total++; if (!hit) begin bad++; $display("[TB] FAIL rstmid_reach: saw %0d enable cycles want 39", seen); end
        resetn = 1'b0;
        #1;
        model_pkts = 0;
        total++; if (gmii.gmii_en !== 1'b0 || gmii.gmii_d !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_bus: en %b d %h want 0 00", gmii.gmii_en, gmii.gmii_d); end
        total++; if (pkts_sent !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_pkts: got %0d want 0", pkts_sent); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 8; c++) begin
            @(negedge clk);
            if (gmii.gmii_en === 1'b1) begin
                pre.push_back(gmii.gmii_d);
                got++;
            end
        end
        total++;
        if (got != 8 || pre[0] !== 8'h55 || pre[6] !== 8'h55 || pre[7] !== 8'hD5) begin
            bad++; $display("[TB] FAIL rstmid_preamble: got %0d bytes want 55x7 d5", got);
        end
        start = 1'b0;
        idle  = 1'b0;
        for (int c = 0; c < 3000 && !idle; c++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1'b1;
        end
        model_pkts += 1;
        total++; if (!idle) begin bad++; $display("[TB] FAIL rstmid_idle: busy never dropped"); end
        total++; if (pkts_sent !== 32'(model_pkts)) begin bad++; $display("[TB] FAIL rstmid_final_pkts: got %0d want %0d", pkts_sent, model_pkts); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_single_frame();
        test_min_clamp();
        test_max_clamp();
        test_stop_continuous();
        test_midframe_change();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gmii_frame_generator.md
GMII_FRAME_GENERATOR -- requirements
Module: gmii_frame_generator

Interface
REQ-001 Parameter C_MAX_FRAME_LEN, default 2044, maximum frame length in bytes, excluding preamble, SFD and FCS.
REQ-002 Parameter C_MIN_IFG, default 12, minimum inter-frame gap in cycles.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  GMII transmit clock; the single clock for all logic.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 start  in  1  level; while high in IDLE, a frame burst begins.
REQ-007 stop  in  1  level; finish the current frame, then return to IDLE.
REQ-008 frame_len  in  16  frame bytes (DA..payload), sampled at each frame start.
REQ-009 ifg_len  in  8  gap in cycles, sampled at each frame start.
REQ-010 frame_count  in  32  frames per burst; 0 means continuous.
REQ-011 dst_mac / src_mac  in  48 each  header fields, sampled at each frame start.
REQ-012 gmii_d  out  8  transmit data.
REQ-013 gmii_en  out  1  transmit enable.
REQ-014 gmii_er  out  1  transmit error; held 0.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse when a finite burst completes.
REQ-017 pkts_sent  out  32  frames sent since reset; wraps modulo 2^32.

Function
REQ-018 States: IDLE, PREAMBLE (7 cycles, 0x55), SFD (1 cycle, 0xD5), DATA (len cycles), FCS (4 cycles), IFG (gap cycles).
REQ-019 gmii_en SHALL be 1 in PREAMBLE/SFD/DATA/FCS and 0 in IDLE/IFG; gmii_d SHALL be 0x00 when gmii_en is 0.
REQ-020 Outputs SHALL be registered; start high in IDLE gives gmii_en=1 with 0x55 on the next clock edge.
REQ-021 Effective len SHALL be frame_len clamped to 14..C_MAX_FRAME_LEN.
REQ-022 Effective gap SHALL be max(ifg_len, C_MIN_IFG).
REQ-023 DATA byte k SHALL be:
- k=0..5: dst_mac, MSB first.
- k=6..11: src_mac, MSB first.
- k=12,13: 0x88, 0xB5.
- k>=14: (seq[7:0] + k - 14) mod 256, where seq is pkts_sent at frame start.
REQ-024 pkts_sent SHALL increment on the last gmii_en cycle of each frame.
REQ-025 At the end of IFG, the block SHALL return to IDLE if stop=1, start=0, or the burst count is reached; otherwise it SHALL go to PREAMBLE.
REQ-026 done SHALL pulse on the IFG-to-IDLE transition only when frame_count≠0 and the count is reached.
REQ-027 stop asserted mid-frame SHALL NOT truncate the frame; the FCS and the full gap still complete.
REQ-028 Changes to frame_len, ifg_len or the MACs mid-frame SHALL affect only the next frame.
REQ-029 start deasserted mid-frame SHALL act as stop.

Reset
REQ-030 Reset SHALL be asynchronous and immediate, including mid-frame: state=IDLE, gmii_d=0, gmii_en=0, gmii_er=0, busy=0, done=0, pkts_sent=0, burst counter=0.
REQ-031 After resetn deasserts, the first frame SHALL start no earlier than the second rising edge of clk.

Configuration
REQ-032 Macro GMII_FRAME_GENERATOR_FCS_EN: when defined, FCS state is present and appends Ethernet CRC-32 over DATA bytes.
- CRC-32: reflected polynomial 0x04C11DB7, init 0xFFFFFFFF, final inversion, transmitted least-significant byte first.
REQ-033 When GMII_FRAME_GENERATOR_FCS_EN is undefined, the FCS state and CRC logic SHALL be absent and DATA SHALL go directly to IFG.

Verification
REQ-034 Length 64, frame_count=1, FCS on -> 7x0x55, 0xD5, 64 bytes, 4 FCS bytes; gmii_en high 76 cycles; done pulse after 12 idle cycles; pkts_sent=1.
REQ-035 FCS check -> running CRC over DATA+FCS equals residue 0xC704DD7B; dst=0x0A0B0C0D0E0F gives bytes 0..5 = 0A 0B 0C 0D 0E 0F; byte 14 of frame 3 = 0x02.
REQ-036 frame_len=5, ifg_len=3, frame_count=3 -> three 14-byte frames; exactly 12 idle cycles between frames; done once.
REQ-037 frame_count=0 with stop raised at DATA byte 20 of frame 2 -> frame 2 completes with FCS and full gap, then IDLE; no done pulse; pkts_sent=2.
REQ-038 resetn low at DATA byte 30 -> gmii_en=0 and pkts_sent=0 before the next edge; start held -> fresh preamble after release.
REQ-039 FCS macro undefined, length 64 -> gmii_en high exactly 72 cycles; the gap follows the last payload byte.
